// File: rtl/fetch_unit_pkg.sv
// Purpose  : shared FSM encoding, instruction field positions and the branch-offset helper for fetch_unit.
// Latency  : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

    localparam int OP_MSB    = 31;
    localparam int OP_W      = 6;
    localparam int OP_LSB    = OP_MSB - OP_W + 1;
    localparam int IMM_W     = 16;
    localparam int JTARGET_W = 26;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Sign-extended word offset of a branch immediate, already scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(32 - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Purpose  : bundles the imem request/response and the instruction hand-off signals of fetch_unit.
// Latency  : n/a (wires only).
// Backpressure: instr_ready is the consumer's stall; imem_ack is the memory's.
// Ports    : master = fetch_unit side, slave = memory + decode/execute side.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [OP_W-1:0]   op;
    logic [31:0]       pc_plus4;
    logic              branch;
    logic              zero;
    logic              jump;
    logic              fetch_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, pc_plus4, fetch_err,
        input  imem_ack, imem_rdata, instr_ready, branch, zero, jump
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, pc_plus4, fetch_err,
        output imem_ack, imem_rdata, instr_ready, branch, zero, jump
    );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Purpose  : selects the pc that follows the held instruction (jump > taken branch > sequential).
// Latency  : combinational.
// Backpressure: none; caller decides when the result is used.
// Ports    : pc_plus4, instr (low 26 bits: jump target, low 16 of those: branch immediate),
//            branch, zero, jump in; next_pc out.
module fetch_unit_next_pc
    import fetch_unit_pkg::*;
(
    input  logic [31:0]          pc_plus4,
    input  logic [JTARGET_W-1:0] instr,
    input  logic                 branch,
    input  logic                 zero,
    input  logic                 jump,
    output logic [31:0]          next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            // Jump keeps the region bits of the sequential pc.
            next_pc = {pc_plus4[31:JTARGET_W+2], instr, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset(instr[IMM_W-1:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Purpose  : non-prefetching instruction fetch: request pc, hold the returned word until consumed, then redirect.
// Latency  : ack in cycle N -> instr_valid in N+1; consume in cycle M -> imem_req at new pc in M+1.
// Backpressure: instr_ready low freezes the held instruction and suppresses further imem requests.
// Ports    : clk, rst (sync, active high), bus (fetch_unit_if.master).
// Config   : FETCH_TIMEOUT_EN adds an imem wait counter that parks the unit in ERR after TIMEOUT_CYC cycles.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    // A zero limit would trip before any request could be answered.
    if (TIMEOUT_CYC == 8'd0) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYC must be nonzero");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + INSTR_BYTES;

    fetch_unit_next_pc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q[JTARGET_W-1:0]),
        .branch   (bus.branch),
        .zero     (bus.zero),
        .jump     (bus.jump),
        .next_pc  (next_pc)
    );

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    logic [7:0] wait_inc;

    assign wait_inc = wait_q + 8'd1;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            ST_REQ: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ST_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_inc >= TIMEOUT_CYC) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_inc;
                end
`endif
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                    wait_d  = 8'd0;
`endif
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
            wait_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Reset sits in REQ so the first post-reset cycle already requests; the
    // request is masked while rst is held so nothing is issued during reset.
    assign bus.imem_req    = (state_q == ST_REQ) && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == ST_HOLD);
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[OP_MSB:OP_LSB];
    assign bus.pc_plus4    = pc_plus4;
`ifdef FETCH_TIMEOUT_EN
    assign bus.fetch_err   = (state_q == ST_ERR);
`else
    assign bus.fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (8'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word on the memory response for one cycle (unit must be in REQ).
    task automatic do_fetch(input logic [31:0] w);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    // Consume the held instruction with the given decode flags.
    task automatic do_consume(input logic b, input logic z, input logic j);
        bus.instr_ready = 1'b1;
        bus.branch      = b;
        bus.zero        = z;
        bus.jump        = j;
        tick();
        bus.instr_ready = 1'b0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        bus.jump        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        @(negedge clk);
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.instr_valid); else n_pass++;
        n_total++; if (bus.instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", bus.instr); else n_pass++;
        n_total++; if (bus.fetch_err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.fetch_err); else n_pass++;
        tick();
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        @(negedge clk);
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL post_rst_req got %b exp 1", bus.imem_req); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL post_rst_addr got %h exp 0", bus.imem_addr); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL post_rst_valid got %b exp 0", bus.instr_valid); else n_pass++;
        tick();
    endtask

    task automatic test_first_fetch();
        @(negedge clk);
        n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL wait_req got %b/%h exp 1/0", bus.imem_req, bus.imem_addr); else n_pass++;
        tick();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        @(negedge clk);
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL ack_cycle_valid got %b exp 0", bus.instr_valid); else n_pass++;
        tick();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        @(negedge clk);
        n_total++; if (bus.instr_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", bus.instr_valid); else n_pass++;
        n_total++; if (bus.instr !== 32'h2008_0005) $display("FAIL first_instr got %h exp 20080005", bus.instr); else n_pass++;
        n_total++; if (bus.op !== 6'h08) $display("FAIL first_op got %h exp 08", bus.op); else n_pass++;
        n_total++; if (bus.pc_plus4 !== 32'h4) $display("FAIL first_pc4 got %h exp 4", bus.pc_plus4); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL hold_req got %b exp 0", bus.imem_req); else n_pass++;
        do_consume(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) $display("FAIL seq_addr got %b/%h exp 1/4", bus.imem_req, bus.imem_addr); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL seq_valid got %b exp 0", bus.instr_valid); else n_pass++;
    endtask

    task automatic test_branch();
        // j 0x10 from pc 4 lands on 0x40.
        do_fetch(32'h0800_0010);
        @(negedge clk);
        n_total++; if (bus.op !== 6'h02) $display("FAIL j_op got %h exp 02", bus.op); else n_pass++;
        do_consume(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h40) $display("FAIL j40_addr got %h exp 40", bus.imem_addr); else n_pass++;
        do_fetch(32'h1000_FFFE);
        @(negedge clk);
        n_total++; if (bus.pc_plus4 !== 32'h44) $display("FAIL beq_pc4 got %h exp 44", bus.pc_plus4); else n_pass++;
        do_consume(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h3C) $display("FAIL beq_taken got %h exp 3c", bus.imem_addr); else n_pass++;
        do_fetch(32'h0000_0020);
        do_consume(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h40) $display("FAIL back_to_40 got %h exp 40", bus.imem_addr); else n_pass++;
        do_fetch(32'h1000_FFFE);
        do_consume(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h44) $display("FAIL beq_not_taken got %h exp 44", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_stall();
        do_fetch(32'hAAAA_5555);
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'h1111_1111 * (i + 1);
            bus.branch     = 1'b1;
            bus.zero       = 1'b1;
            bus.jump       = 1'b1;
            @(negedge clk);
            n_total++; if (bus.instr !== 32'hAAAA_5555) $display("FAIL stall_instr[%0d] got %h exp aaaa5555", i, bus.instr); else n_pass++;
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req[%0d] got %b exp 0", i, bus.imem_req); else n_pass++;
            n_total++; if (bus.instr_valid !== 1'b1 || bus.pc_plus4 !== 32'h48) $display("FAIL stall_hold[%0d] got %b/%h exp 1/48", i, bus.instr_valid, bus.pc_plus4); else n_pass++;
            tick();
        end
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.branch = 1'b0;
        bus.zero = 1'b0;
        bus.jump = 1'b0;
        do_consume(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h48) $display("FAIL stall_next got %h exp 48", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_jump_priority();
        do_fetch(32'h0BFF_FFFF);
        do_consume(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h0FFF_FFFC) $display("FAIL jmax_addr got %h exp 0ffffffc", bus.imem_addr); else n_pass++;
        do_fetch(32'h0000_0020);
        @(negedge clk);
        n_total++; if (bus.pc_plus4 !== 32'h1000_0000) $display("FAIL carry_pc4 got %h exp 10000000", bus.pc_plus4); else n_pass++;
        do_consume(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h1000_0000) $display("FAIL region_addr got %h exp 10000000", bus.imem_addr); else n_pass++;
        do_fetch(32'h0800_0010);
        @(negedge clk);
        n_total++; if (bus.pc_plus4 !== 32'h1000_0004) $display("FAIL jp_pc4 got %h exp 10000004", bus.pc_plus4); else n_pass++;
        do_consume(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h1000_0040) $display("FAIL jump_prio got %h exp 10000040", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) $display("FAIL rstreq_addr got %h/%b exp 0/1", bus.imem_addr, bus.imem_req); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) $display("FAIL rstreq_instr got %b/%h exp 0/0", bus.instr_valid, bus.instr); else n_pass++;
        do_fetch(32'h1234_5678);
        @(negedge clk);
        n_total++; if (bus.instr_valid !== 1'b1) $display("FAIL prehold_valid got %b exp 1", bus.instr_valid); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) $display("FAIL rsthold got %b/%h exp 0/0", bus.instr_valid, bus.instr); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) $display("FAIL rsthold_req got %h/%b exp 0/1", bus.imem_addr, bus.imem_req); else n_pass++;
    endtask

    task automatic test_wrap();
        do_fetch(32'h1000_FFFE);
        do_consume(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL neg_branch got %h exp fffffffc", bus.imem_addr); else n_pass++;
        do_fetch(32'h0000_0020);
        @(negedge clk);
        n_total++; if (bus.pc_plus4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", bus.pc_plus4); else n_pass++;
        do_consume(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) $display("FAIL wrap_addr got %h/%b exp 0/1", bus.imem_addr, bus.imem_req); else n_pass++;
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++; if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b1) $display("FAIL to_wait[%0d] got %b/%b exp 0/1", i, bus.fetch_err, bus.imem_req); else n_pass++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = 32'h5555_0000 + i;
            @(negedge clk);
            n_total++; if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0) $display("FAIL to_err[%0d] got %b/%b exp 1/0", i, bus.fetch_err, bus.imem_req); else n_pass++;
            n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL to_valid[%0d] got %b exp 0", i, bus.instr_valid); else n_pass++;
            tick();
        end
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b1) $display("FAIL to_clear got %b/%b exp 0/1", bus.fetch_err, bus.imem_req); else n_pass++;
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_total++; if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b1) $display("FAIL no_to[%0d] got %b/%b exp 0/1", i, bus.fetch_err, bus.imem_req); else n_pass++;
            tick();
        end
`endif
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        bus.jump        = 1'b0;
        test_reset();
        test_first_fetch();
        test_branch();
        test_stall();
        test_jump_priority();
        test_reset_mid();
        test_wrap();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
